// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO console UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; writes when full
// and reads when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally; count tracks occupancy on the pre-edge state.
  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO-store-fed 8N1 UART transmitter: buffers the low byte of each store
// and serialises it LSB first with gapless back-to-back frames.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mmio_wea,
  input  logic [31:0] mmio_dat,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state, state_d;
  logic [BAUD_W-1:0]         baud, baud_d;
  logic [2:0]                bit_idx, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift, shift_d;
  logic                      tx_d;
  logic                      pop;
  logic                      bit_done;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      unused_dat;

  assign unused_dat = ^mmio_dat[31:8];

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .Rst   (Rst),
    .push  (mmio_wea),
    .pop   (pop),
    .din   (mmio_dat[UART_DATA_BITS-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy     = (state != IDLE) || !fifo_empty;
  assign bit_done = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (Rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
      overflow <= overflow || (mmio_wea && fifo_full);
    end
  end

  // Next state; tx is registered from the post-edge state so it never glitches.
  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) state_d = STOP;
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: small-baud instance for function and
// boundaries, default-baud instance for bit timing.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        wea = 1'b0;
  logic [31:0] dat = '0;
  logic        tx, busy, full, empty, ov;
  logic        wea2 = 1'b0;
  logic [31:0] dat2 = '0;
  logic        tx2, busy2, full2, empty2, ov2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .Rst(Rst), .mmio_wea(wea), .mmio_dat(dat),
    .tx(tx), .busy(busy), .fifo_full(full), .fifo_empty(empty), .overflow(ov)
  );

  mmio_uart_tx dut_def (
    .clk(clk), .Rst(Rst), .mmio_wea(wea2), .mmio_dat(dat2),
    .tx(tx2), .busy(busy2), .fifo_full(full2), .fifo_empty(empty2), .overflow(ov2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  // Checks frame cycles from..39 of byte b, starting at the current cycle.
  task automatic check_frame(input logic [7:0] b, input int from);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = from; i < 40; i++) begin
      check($sformatf("frame_%02h_c%0d", b, i), 32'(tx), 32'(f[i/4]));
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    int n;
    bit bad;

    // Reset values
    do_reset();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ovf", 32'(ov), 32'd0);

    // Single byte: upper data bits ignored, start one cycle after the push
    wea = 1'b1; dat = 32'hDEAD_BE41;
    tick();
    wea = 1'b0;
    check("single_empty", 32'(empty), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_tx_pre", 32'(tx), 32'd1);
    tick();
    check_frame(8'h41, 0);
    check_idle("single_end");

    // Burst of three gapless frames
    wea = 1'b1; dat = 32'h55; tick();
    dat = 32'hAA; tick();
    dat = 32'h0F; tick();
    wea = 1'b0;
    check_frame(8'h55, 1);
    check_frame(8'hAA, 0);
    check_frame(8'h0F, 0);
    check_idle("burst_end");

    // Overflow: six writes, the sixth is dropped
    for (int i = 0; i < 6; i++) begin
      wea = 1'b1; dat = 32'(i + 1);
      tick();
      if (i == 4) begin
        check("ovf_full_before", 32'(full), 32'd1);
        check("ovf_flag_before", 32'(ov), 32'd0);
      end
    end
    wea = 1'b0;
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(ov), 32'd1);
    check_frame(8'h01, 4);
    for (int b = 2; b <= 5; b++) check_frame(8'(b), 0);
    check_idle("ovf_end");
    check("ovf_sticky", 32'(ov), 32'd1);

    // Push on the same edge as a STOP-expiry pop while full
    do_reset();
    check("pop_rst_ovf", 32'(ov), 32'd0);
    for (int i = 0; i < 5; i++) begin
      wea = 1'b1; dat = 32'(8'h11 + i);
      tick();
    end
    wea = 1'b0;
    repeat (36) tick();
    check("pop_full_pre", 32'(full), 32'd1);
    wea = 1'b1; dat = 32'h77;
    tick();
    wea = 1'b0;
    check("pop_ovf", 32'(ov), 32'd1);
    check("pop_full_post", 32'(full), 32'd0);
    check_frame(8'h12, 0);
    check_frame(8'h13, 0);
    check_frame(8'h14, 0);
    check_frame(8'h15, 0);
    check_idle("pop_end");
    bad = 1'b0;
    repeat (50) begin
      if (tx !== 1'b1) bad = 1'b1;
      tick();
    end
    check("pop_no_extra_frame", 32'(bad), 32'd0);

    // Reset during data bit 3 with the FIFO full and overflow set
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wea = 1'b1; dat = 32'(8'hC0 + i);
      tick();
    end
    wea = 1'b0;
    repeat (13) tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    check("mid_ovf_pre", 32'(ov), 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check_idle("mid_rst");
    check("mid_ovf", 32'(ov), 32'd0);
    check("mid_full", 32'(full), 32'd0);
    bad = 1'b0;
    repeat (60) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    check("mid_quiet", 32'(bad), 32'd0);

    // Default baud: 0x80 gives 8 low bits then data bit 7 and stop high
    wea2 = 1'b1; dat2 = 32'h80;
    tick();
    wea2 = 1'b0;
    tick();
    check("def_start", 32'(tx2), 32'd0);
    n = 0;
    while (tx2 === 1'b0 && n < 20000) begin
      tick();
      n++;
    end
    check("def_low_run", 32'(n), 32'd6944);
    while (busy2 === 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    check("def_frame_len", 32'(n), 32'd8680);
    check("def_tx_idle", 32'(tx2), 32'd1);
    check("def_empty", 32'(empty2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that consumes the memory stage's MMIO store strobe and data (`mmio_wea`, `mmio_dat`) and serialises the low byte onto a `tx` pin as 8N1 frames. It sits downstream of the memory stage, alongside the core top. It gives running programs a console output path, complementing the UART programming input. A small FIFO decouples single-cycle store bursts from the slow serial line.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, default 16: byte entries; power of two, ≥ 2.
- `clk`  in  1  system clock.
- `Rst`  in  1  reset; synchronous, active-high, sampled on the rising edge of `clk`.
- `mmio_wea`  in  1  single-cycle write strobe from the memory stage.
- `mmio_dat`  in  32  store data; only `[7:0]` is transmitted, `[31:8]` is ignored.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `fifo_full`  out  1  count == `FIFO_DEPTH`.
- `fifo_empty`  out  1  count == 0.
- `overflow`  out  1  sticky flag: a write was dropped because the FIFO was full.

## Operation
- **Push:** on an edge with `mmio_wea`=1 and `fifo_full`=0, write `mmio_dat[7:0]` at the write pointer.
  - Full is judged on the pre-edge count.
  - A write while full is dropped and sets `overflow`, even if a pop occurs on the same edge.
- **Pop:** happens only when the FSM leaves IDLE or STOP into START. The byte is loaded into an 8-bit shift register.
- **Simultaneous push and pop** (non-full): count is unchanged and both pointers advance.
- **Pointers:** log2(`FIFO_DEPTH`) bits, natural wrap. Count is log2(`FIFO_DEPTH`)+1 bits.
- **FSM states (`tx_state_t`):** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty: pop, clear the baud counter, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts `CLKS_PER_BIT` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At expiry: if the FIFO is non-empty, pop and go straight to START (gapless); otherwise go to IDLE.
- **Registers:**
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1; a bit ends when it reaches terminal count.
  - Bit index: 3 bits.
- **Reset values:** `tx`=1, `busy`=0, `fifo_full`=0, `fifo_empty`=1, `overflow`=0, FSM=IDLE, pointers, count and baud counter = 0.
- **Reset mid-frame:** the frame is aborted, `tx` is high on the cycle after the reset edge, FIFO contents are discarded, and `overflow` is cleared. `overflow` is cleared only by `Rst`.

## Timing
- `tx` is registered (no combinational path from inputs).
- **Latency:** a push at edge k into an empty FIFO with the FSM in IDLE makes `fifo_empty` low after edge k. The FSM pops at edge k+1, so `tx` falls after edge k+1 (one cycle of write-to-start latency).
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles.
- **Back-to-back frames:** the next start bit follows the stop bit with zero idle cycles.
- **Status outputs:** `fifo_full`, `fifo_empty` and `busy` reflect post-edge state.
- **`overflow`:** rises the cycle after the dropped write.
- **Throughput:** one byte per 10×`CLKS_PER_BIT`. The producer may issue `mmio_wea` every cycle; no backpressure is given to the pipeline.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}`
  - localparams `UART_DATA_BITS`=8 and `UART_DEFAULT_CLKS_PER_BIT`=868.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - ports: push, pop, din, dout, full, empty.
  - `dout` shows the head entry combinationally (first-word fall-through).
- `mmio_uart_tx` holds the FSM, baud counter, shift register, bit index and overflow logic.

## Test plan
Use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 unless noted.
- **Single byte:** `mmio_wea` pulse with `mmio_dat`=32'hDEAD_BE41 → `tx` falls 1 cycle later. Bits 1,0,0,0,0,0,1,0 (0x41, LSB first) follow, each 4 cycles, then stop=1. `busy` deasserts after 40 cycles.
- **Burst:** 3 consecutive-cycle writes 0x55, 0xAA, 0x0F → three gapless frames, 120 cycles total, bytes in order, `fifo_empty` returns to 1.
- **Overflow:** 6 consecutive writes 0x01..0x06 → 0x01 popped at k+1; 0x02..0x05 fill the FIFO; 0x06 is dropped. `fifo_full`=1 and `overflow`=1 the cycle after 0x06. Five frames are transmitted.
- **Push on pop:** FIFO full while STOP expires, with `mmio_wea` asserted on the same edge → the write is dropped, `overflow`=1, count goes to 3.
- **Reset mid-frame:** assert `Rst` during DATA bit 3 → `tx`=1 the next cycle, `fifo_empty`=1, `busy`=0, `overflow`=0, and no further frames.
- **Default baud:** `CLKS_PER_BIT`=868, byte 0x80 → each bit lasts 868 cycles and the stop bit ends 8680 cycles after the start bit falls.
